uart_tx_fifo: RTL and testbench

//   Transmit-side UART stage that consumes bytes produced by the RISC-V core's store path.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the default bit period.
// The receive stage will import the same package.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 100 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count and registered full/empty flags.
// The head entry is always visible on head, so a pop consumes it in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    next_count;

    // A push is refused whenever the registered count says full, even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        next_count = count;
        if (do_push && !do_pop) begin
            next_count = count + 1'b1;
        end else if (!do_push && do_pop) begin
            next_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;
            full  <= (next_count == CW'(DEPTH));
            empty <= (next_count == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes from the core queue in a FIFO and are shifted out LSB first.
// Line, busy and done outputs are registered views of the FSM, so they trail the state by one cycle.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BCW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW  = $clog2(DATA_W);
    localparam logic [BCW-1:0] BAUD_LOAD = BCW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  BIT_LAST  = IW'(DATA_W - 1);

    uart_state_t        state;
    logic [BCW-1:0]     baud_cnt;
    logic [IW-1:0]      bit_idx;
    logic [DATA_W-1:0]  shift;
    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    // Popping from STOP as well as IDLE is what keeps back-to-back frames contiguous.
    assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & (baud_cnt == '0)));
    assign wr_ready = ~fifo_full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
            tx_done  <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            uart_tx <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
            tx_done <= (state == STOP) && (baud_cnt == '0);
            tx_busy <= (state != IDLE) || !fifo_empty;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift    <= fifo_head;
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        shift    <= shift >> 1;
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == '0) begin
                        if (!fifo_empty) begin
                            shift    <= fifo_head;
                            bit_idx  <= '0;
                            baud_cnt <= BAUD_LOAD;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line activity is logged per cycle and compared against an 8N1 frame model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;
    localparam int HMASK = 8191;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 'x;
    logic       wr_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;
    logic [3:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic line_hist [8192];
    logic busy_hist [8192];
    logic done_hist [8192];
    logic [7:0] exp_bytes [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Index h holds the outputs as they stand after the h-th rising edge.
    always @(negedge clk) begin
        line_hist[cyc & HMASK] = uart_tx;
        busy_hist[cyc & HMASK] = tx_busy;
        done_hist[cyc & HMASK] = tx_done;
    end

    // Expected line level in cycle k (1-based) of a contiguous stream of exp_bytes frames.
    function automatic logic model_line(input int k);
        int idx, f, p;
        logic [7:0] b;
        idx = k - 1;
        f = idx / FRAME;
        p = (idx % FRAME) / CPB;
        if (f >= exp_bytes.size()) return 1'b1;
        b = exp_bytes[f];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_valid = 1'b0;
        wr_data = 'x;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic push_bytes(input int n, output int first);
        first = 0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data = exp_bytes[i];
            @(negedge clk);
            if (i == 0) first = cyc;
        end
        wr_valid = 1'b0;
        wr_data = 'x;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (uart_tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        if (tx_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_done: got %b expected 0", tx_done); end
        if (fifo_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int n0, dones;
        logic [9:0] pat;
        pat = 10'b1010000010;
        do_reset();
        exp_bytes = {8'h41};
        push_bytes(1, n0);
        checks++;
        if (fifo_count !== 4'd1) begin failures++; $display("[TB] FAIL single_count_after_push: got %0d expected 1", fifo_count); end
        wait_cyc(n0 + 52);
        checks += 3;
        if (line_hist[(n0 + 1) & HMASK] !== 1'b1) begin failures++; $display("[TB] FAIL single_latency_high: got %b expected 1", line_hist[(n0 + 1) & HMASK]); end
        if (line_hist[(n0 + 2) & HMASK] !== 1'b0) begin failures++; $display("[TB] FAIL single_latency_start: got %b expected 0", line_hist[(n0 + 2) & HMASK]); end
        if (busy_hist[(n0 + 2) & HMASK] !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_in_frame: got %b expected 1", busy_hist[(n0 + 2) & HMASK]); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (line_hist[(n0 + 1 + i * CPB + 2) & HMASK] !== pat[i]) begin
                failures++;
                $display("[TB] FAIL single_bit%0d: got %b expected %b", i, line_hist[(n0 + 1 + i * CPB + 2) & HMASK], pat[i]);
            end
        end
        dones = 0;
        for (int h = n0 + 1; h <= n0 + 51; h++) if (done_hist[h & HMASK] === 1'b1) dones++;
        checks += 3;
        if (dones !== 1) begin failures++; $display("[TB] FAIL single_done_count: got %0d expected 1", dones); end
        if (done_hist[(n0 + 1 + FRAME) & HMASK] !== 1'b1) begin failures++; $display("[TB] FAIL single_done_cycle40: got %b expected 1", done_hist[(n0 + 1 + FRAME) & HMASK]); end
        if (busy_hist[(n0 + 2 + FRAME) & HMASK] !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy_hist[(n0 + 2 + FRAME) & HMASK]); end
    endtask

    task automatic test_back_to_back();
        int n0, errs;
        do_reset();
        exp_bytes = {8'h55, 8'hAA};
        push_bytes(2, n0);
        wait_cyc(n0 + 2 * FRAME + 5);
        for (int f = 0; f < 2; f++) begin
            errs = 0;
            for (int k = f * FRAME + 1; k <= (f + 1) * FRAME; k++) begin
                if (line_hist[(n0 + 1 + k) & HMASK] !== model_line(k)) errs++;
                if (done_hist[(n0 + 1 + k) & HMASK] !== (k % FRAME == 0)) errs++;
            end
            checks++;
            if (errs !== 0) begin failures++; $display("[TB] FAIL b2b_frame%0d: got %0d bad cycles expected 0", f, errs); end
        end
        checks += 2;
        if (line_hist[(n0 + 2 + 2 * FRAME) & HMASK] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_line_after: got %b expected 1", line_hist[(n0 + 2 + 2 * FRAME) & HMASK]); end
        if (busy_hist[(n0 + 2 + 2 * FRAME) & HMASK] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_after: got %b expected 0", busy_hist[(n0 + 2 + 2 * FRAME) & HMASK]); end
    endtask

    task automatic test_random_stream();
        int n0, errs;
        do_reset();
        exp_bytes = {};
        for (int i = 0; i < 4; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        push_bytes(4, n0);
        wait_cyc(n0 + 4 * FRAME + 5);
        for (int f = 0; f < 4; f++) begin
            errs = 0;
            for (int k = f * FRAME + 1; k <= (f + 1) * FRAME; k++) begin
                if (line_hist[(n0 + 1 + k) & HMASK] !== model_line(k)) errs++;
            end
            checks++;
            if (errs !== 0) begin failures++; $display("[TB] FAIL random_frame%0d byte %02h: got %0d bad cycles expected 0", f, exp_bytes[f], errs); end
        end
    endtask

    task automatic test_fill();
        int n0, errs, accepted;
        logic ready_before;
        int exp_cnt;
        do_reset();
        exp_bytes = {};
        for (int i = 0; i < 10; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        accepted = 0;
        n0 = 0;
        for (int j = 0; j < 30; j++) begin
            ready_before = wr_ready;
            wr_valid = 1'b1;
            wr_data = exp_bytes[accepted];
            @(negedge clk);
            if (ready_before === 1'b1) accepted++;
            if (j == 0) n0 = cyc;
            exp_cnt = (j == 0) ? 1 : ((j > DEPTH) ? DEPTH : j);
            checks += 2;
            if (wr_ready !== (j < DEPTH)) begin failures++; $display("[TB] FAIL fill_ready_j%0d: got %b expected %b", j, wr_ready, (j < DEPTH)); end
            if (fifo_count !== 4'(exp_cnt)) begin failures++; $display("[TB] FAIL fill_count_j%0d: got %0d expected %0d", j, fifo_count, exp_cnt); end
        end
        wr_valid = 1'b0;
        wr_data = 'x;
        checks++;
        if (accepted !== 9) begin failures++; $display("[TB] FAIL fill_accepted: got %0d expected 9", accepted); end
        void'(exp_bytes.pop_back());
        wait_cyc(n0 + 9 * FRAME + 5);
        errs = 0;
        for (int k = 1; k <= 9 * FRAME + 2; k++) begin
            if (line_hist[(n0 + 1 + k) & HMASK] !== model_line(k)) errs++;
        end
        checks += 2;
        if (errs !== 0) begin failures++; $display("[TB] FAIL fill_stream: got %0d bad cycles expected 0", errs); end
        if (busy_hist[(n0 + 2 + 9 * FRAME) & HMASK] !== 1'b0) begin failures++; $display("[TB] FAIL fill_busy_after: got %b expected 0", busy_hist[(n0 + 2 + 9 * FRAME) & HMASK]); end
    endtask

    task automatic test_reset_mid_frame();
        int n0, errs, lows, dones;
        do_reset();
        exp_bytes = {8'h41};
        for (int i = 0; i < 3; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        push_bytes(4, n0);
        checks++;
        if (fifo_count !== 4'd3) begin failures++; $display("[TB] FAIL midrst_queued: got %0d expected 3", fifo_count); end
        // Edge n0+19 falls inside data bit 3 of the first frame.
        wait_cyc(n0 + 18);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (uart_tx !== 1'b1) begin failures++; $display("[TB] FAIL midrst_uart_tx: got %b expected 1", uart_tx); end
        if (fifo_count !== 4'd0) begin failures++; $display("[TB] FAIL midrst_fifo_count: got %0d expected 0", fifo_count); end
        if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_tx_busy: got %b expected 0", tx_busy); end
        rst_n = 1'b1;
        errs = 0;
        for (int k = 1; k <= 16; k++) if (line_hist[(n0 + 1 + k) & HMASK] !== model_line(k)) errs++;
        checks++;
        if (errs !== 0) begin failures++; $display("[TB] FAIL midrst_partial_frame: got %0d bad cycles expected 0", errs); end
        repeat (200) @(negedge clk);
        lows = 0;
        dones = 0;
        for (int h = n0 + 19; h < cyc; h++) begin
            if (line_hist[h & HMASK] !== 1'b1) lows++;
            if (done_hist[h & HMASK] !== 1'b0) dones++;
        end
        checks += 2;
        if (lows !== 0) begin failures++; $display("[TB] FAIL midrst_no_frames: got %0d non-idle cycles expected 0", lows); end
        if (dones !== 0) begin failures++; $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", dones); end
    endtask

    task automatic test_full_push_pop();
        int n0, errs, accepted;
        logic ready_before;
        do_reset();
        exp_bytes = {};
        for (int i = 0; i < 9; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        accepted = 0;
        n0 = 0;
        ready_before = 1'b0;
        // Keep offering a byte through edge n0+41, where the first frame pops the FIFO.
        for (int j = 0; j <= 41; j++) begin
            ready_before = wr_ready;
            wr_valid = 1'b1;
            wr_data = (accepted < 9) ? exp_bytes[accepted] : 8'hEE;
            @(negedge clk);
            if (ready_before === 1'b1) accepted++;
            if (j == 0) n0 = cyc;
        end
        wr_valid = 1'b0;
        wr_data = 'x;
        checks += 3;
        if (ready_before !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_at_pop: got %b expected 0", ready_before); end
        if (fifo_count !== 4'd7) begin failures++; $display("[TB] FAIL full_count_after_pop: got %0d expected 7", fifo_count); end
        if (accepted !== 9) begin failures++; $display("[TB] FAIL full_accepted: got %0d expected 9", accepted); end
        wait_cyc(n0 + 10 * FRAME + 5);
        errs = 0;
        for (int k = 1; k <= 10 * FRAME + 2; k++) begin
            if (line_hist[(n0 + 1 + k) & HMASK] !== model_line(k)) errs++;
        end
        checks++;
        if (errs !== 0) begin failures++; $display("[TB] FAIL full_stream: got %0d bad cycles expected 0", errs); end
    endtask

    task automatic test_idle();
        int n0, lows, busys, dones;
        do_reset();
        n0 = cyc;
        repeat (1000) @(negedge clk);
        lows = 0;
        busys = 0;
        dones = 0;
        for (int h = n0; h < cyc; h++) begin
            if (line_hist[h & HMASK] !== 1'b1) lows++;
            if (busy_hist[h & HMASK] !== 1'b0) busys++;
            if (done_hist[h & HMASK] !== 1'b0) dones++;
        end
        checks += 3;
        if (lows !== 0) begin failures++; $display("[TB] FAIL idle_line: got %0d low cycles expected 0", lows); end
        if (busys !== 0) begin failures++; $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busys); end
        if (dones !== 0) begin failures++; $display("[TB] FAIL idle_done: got %0d pulses expected 0", dones); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_stream();
        test_fill();
        test_reset_mid_frame();
        test_full_push_pop();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
